// File: rtl/audio_pkg.sv
// Shared audio-path constants and the sample type used by the shaper and DAC sides.
package audio_pkg;
    localparam int AUDIO_WIDTH    = 8;
    localparam int SAMPLE_DIV_48K = 500;
    localparam int CLK_HZ         = 24_000_000;

    typedef logic [AUDIO_WIDTH-1:0] audio_sample_t;
endpackage

// File: rtl/audio_dsm_tx_if.sv
// Valid/ready sample stream from the shaper into the delta-sigma transmitter.
interface audio_dsm_tx_if
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/sample_fifo2.sv
// Two-entry shift-register FIFO; entry 0 is always the head, no bypass path.
module sample_fifo2
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       level
);
    logic [1:0][WIDTH-1:0] mem;

    assign dout = mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            level <= 2'd0;
        end else begin
            case (level)
                2'd0: begin
                    // A pop on empty is ignored: the pushed word must land first.
                    if (push) begin
                        mem[0] <= din;
                        level  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        mem[0] <= din;
                    end else if (push) begin
                        mem[1] <= din;
                        level  <= 2'd2;
                    end else if (pop) begin
                        level  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        mem[0] <= mem[1];
                        level  <= 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/audio_dsm_tx.sv
// Sample-rate FIFO drain plus first-order delta-sigma modulator driving one DAC pin.
module audio_dsm_tx
    import audio_pkg::*;
#(
    parameter int WIDTH      = AUDIO_WIDTH,
    parameter int SAMPLE_DIV = SAMPLE_DIV_48K
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    audio_dsm_tx_if.slave s,
    input  logic          clr_underrun,
    output logic          dac_out,
    output logic          sample_tick,
    output logic          underrun,
    output logic [1:0]    fifo_level
);
    localparam int            CW       = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cur_sample;
    logic [WIDTH-1:0] head;
    logic [WIDTH:0]   sum;
    logic             tick;
    logic             push;
    logic             pop;

    assign tick        = ena && (cnt == CNT_LAST);
    assign sample_tick = tick;
    // rst_n gates ready so the producer never sees an accept while reset is held.
    assign s.s_ready   = rst_n && ena && (fifo_level != 2'd2);
    assign push        = s.s_valid && s.s_ready;
    assign pop         = tick && (fifo_level != 2'd0);
    assign sum         = {1'b0, acc} + {1'b0, cur_sample};

    sample_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (s.s_data),
        .dout  (head),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            cur_sample <= '0;
            dac_out    <= 1'b0;
            underrun   <= 1'b0;
        end else if (ena) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (pop)
                cur_sample <= head;
            // An empty-FIFO tick outranks a simultaneous clear.
            if (tick && fifo_level == 2'd0)
                underrun <= 1'b1;
            else if (clr_underrun)
                underrun <= 1'b0;
            {dac_out, acc} <= sum;
        end
    end
endmodule

// File: doc/audio_dsm_tx.md
Name: audio_dsm_tx

Overview:
- Output-side companion to the transient shaper: accepts processed WIDTH-bit audio samples from the shaper path over a valid/ready handshake.
- Buffers samples in a 2-entry FIFO and releases one sample per sample period.
- Converts the current sample to a 1-bit first-order delta-sigma stream on one pin, for an external RC filter.
- Flags underrun when the producer misses a sample period.

Parameters:
- WIDTH, 8, sample width in bits; samples are unsigned offset-binary, 0 .. 2^WIDTH-1.
- SAMPLE_DIV, 500, clk cycles per sample period; 24 MHz / 500 = 48 kHz. Legal range 2..65535.

Ports:
- clk  in  1  system clock, 24 MHz
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; low freezes all state
- s_data  in  WIDTH  sample from shaper
- s_valid  in  1  s_data valid
- s_ready  out  1  block can accept s_data this cycle
- clr_underrun  in  1  synchronous clear of underrun flag
- dac_out  out  1  delta-sigma bitstream, registered
- sample_tick  out  1  one-cycle pulse at each sample boundary
- underrun  out  1  sticky: a tick found the FIFO empty
- fifo_level  out  2  FIFO occupancy, 0..2

Behaviour:
- Reset (rst_n low, asynchronous): dac_out=0, sample_tick=0, underrun=0, fifo_level=0, s_ready=0 while rst_n low. FIFO, tick counter, accumulator and current sample all clear to 0. Deassertion takes effect at the next clk edge. Reset mid-stream discards buffered samples.
- ena low: counter, FIFO, accumulator, dac_out and underrun hold; sample_tick=0; s_ready=0. All inputs are ignored.
- s_ready = ena && (fifo_level < 2), from registered level only.
- Push occurs on a cycle with s_valid && s_ready. s_data is captured at that edge. The producer holds s_data and s_valid until accepted.
- Tick counter: counts 0..SAMPLE_DIV-1 with ena high and wraps to 0. sample_tick=1 for the single cycle where count == SAMPLE_DIV-1. The first tick occurs SAMPLE_DIV cycles after reset release (with ena high).
- On a tick edge:
  - FIFO non-empty: pop the head into cur_sample.
  - FIFO empty: cur_sample holds its old value and underrun is set to 1.
- Simultaneous push and tick:
  - FIFO level 1: pop and push both occur; level stays 1; the new sample becomes the head next cycle.
  - FIFO level 0: no bypass. The pushed sample enters the FIFO, the tick counts as an underrun, and cur_sample is unchanged.
  - FIFO full: s_ready=0, so no push happens that cycle even though a pop occurs.
- clr_underrun: clears underrun at the next edge. If an underrun event occurs in the same cycle, set wins.
- Delta-sigma:
  - acc is a WIDTH-bit register. Each enabled cycle: {carry, acc} <= acc + cur_sample (WIDTH+1-bit sum); dac_out <= carry.
  - The density of ones equals cur_sample / 2^WIDTH exactly over any 2^WIDTH-cycle window with constant input.
  - cur_sample=0 gives all zeros. cur_sample=2^WIDTH-1 gives exactly one 0 per 2^WIDTH cycles.
  - A new cur_sample takes effect on the accumulator the cycle after the tick. The accumulator is not reset at sample boundaries.
- Latency: a sample pushed into an empty FIFO appears in cur_sample at the next tick; its first influence on dac_out is 2 cycles after that tick.

Decomposition:
- Package audio_pkg holds:
  - AUDIO_WIDTH = 8
  - SAMPLE_DIV_48K = 500
  - CLK_HZ = 24_000_000
  - typedef audio_sample_t (logic [AUDIO_WIDTH-1:0]), shared with the shaper side.
- One sub-module, sample_fifo2: 2-entry register FIFO with push/pop and level, and no bypass.
- Tick counter, underrun flag and delta-sigma accumulator live in the top of audio_dsm_tx.

Test Plan:
- Reset/idle: hold rst_n low 5 cycles, release with ena=1 and no pushes → dac_out stays 0; sample_tick pulses at cycles SAMPLE_DIV, 2·SAMPLE_DIV; underrun=1 after the first tick.
- Density: SAMPLE_DIV=8, push 0x40 then 0xC0, then keep the FIFO topped up → count ones over 256 cycles after each sample takes effect: exactly 64 and 192.
- Extremes: sustained 0x00 → zero ones in 256 cycles. Sustained 0xFF → exactly 255 ones per 256 cycles.
- Backpressure: SAMPLE_DIV=8, s_valid held high with data 1,2,3,4 → s_ready drops at fifo_level=2; cur_sample order 1,2,3,4 with no loss or duplication.
- Underrun: stop pushing → at the next tick underrun=1 and cur_sample holds its last value. Pulse clr_underrun with the FIFO refilled → underrun=0. Assert clr_underrun coincident with an empty-FIFO tick → underrun stays 1.
- Corner cases:
  - ena low for 20 cycles mid-period → counter, dac_out and fifo_level frozen; s_ready=0; the tick is delayed by exactly 20 cycles.
  - Async rst_n pulse mid-cycle with level=2 → fifo_level=0 and dac_out=0 immediately, before the next clk edge.
